// File: rtl/cross_clk_handshake_tx.sv
// Source side of a 4-phase req/ack crossing: takes one word on valid/ready, holds it on tx_data
// under tx_req until the synchronized ack completes both phases. Optional timeout: CROSS_CLK_TIMEOUT_EN.
module cross_clk_handshake_tx #(
  parameter int LAT       = 2,
  parameter int DSIZE     = 8,
  parameter int TO_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DSIZE-1:0] s_data,
  output logic             tx_req,
  output logic [DSIZE-1:0] tx_data,
  input  logic             rx_ack,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] REL  = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic             req_reg, req_next;
  logic [DSIZE-1:0] data_reg, data_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic [LAT-1:0]   ack_sync_reg;
  logic             ack_s;
  logic             timeout;

  // rx_ack is asynchronous to clk; only the last flop of this chain feeds the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync_reg <= '0;
    end else begin
      ack_sync_reg <= {ack_sync_reg[LAT-2:0], rx_ack};
    end
  end

  assign ack_s = ack_sync_reg[LAT-1];

`ifdef CROSS_CLK_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);

  logic [CW-1:0] cnt_reg, cnt_next;

  // Fires on the edge where the per-phase count would reach TO_CYCLES.
  assign timeout = (cnt_reg == CW'(TO_CYCLES - 1));

  always_comb begin
    cnt_next = '0;
    if ((state_next == state_reg) && (state_reg != IDLE)) begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    data_next  = data_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (s_valid) begin
          state_next = REQ;
          req_next   = 1'b1;
          data_next  = s_data;
        end
      end
      REQ: begin
        // A stale ack already high on entry is taken as the acknowledge.
        if (ack_s) begin
          state_next = REL;
          req_next   = 1'b0;
          done_next  = 1'b1;
        end else if (timeout) begin
          state_next = REL;
          req_next   = 1'b0;
          err_next   = 1'b1;
        end
      end
      REL: begin
        if (!ack_s) begin
          state_next = IDLE;
        end else if (timeout) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      req_reg   <= 1'b0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign s_ready = (state_reg == IDLE);
  assign busy    = ~s_ready;
  assign tx_req  = req_reg;
  assign tx_data = data_reg;
  assign done    = done_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_cross_clk_handshake_tx.sv
// Bench for cross_clk_handshake_tx: destination modelled as tx_req delayed 3 cycles of an offset clock;
// a second instance with LAT=3 is driven by hand for the ack latency check.
module tb_cross_clk_handshake_tx;

  logic       clk = 1'b0;
  logic       clk_d = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready, tx_req, rx_ack, done, busy, err;
  logic [7:0] tx_data;
  logic       s_valid3 = 1'b0;
  logic [7:0] s_data3 = 8'h00;
  logic       rx_ack3 = 1'b0;
  logic       s_ready3, tx_req3, done3, busy3, err3;
  logic [7:0] tx_data3;

  int n_checks = 0;
  int n_fail = 0;
  int ack_mode = 0;  // 0: destination model, 1: stuck 0, 2: stuck 1
  logic [2:0] ack_pipe;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  initial begin
    #3;
    forever #7 clk_d = ~clk_d;
  end

  always @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) ack_pipe <= 3'b000;
    else ack_pipe <= {ack_pipe[1:0], tx_req};
  end
  assign rx_ack = (ack_mode == 0) ? ack_pipe[2] : (ack_mode == 2);

  cross_clk_handshake_tx #(.LAT(2), .DSIZE(8), .TO_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .tx_req(tx_req), .tx_data(tx_data), .rx_ack(rx_ack), .done(done), .busy(busy), .err(err)
  );

  cross_clk_handshake_tx #(.LAT(3), .DSIZE(8), .TO_CYCLES(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3),
    .tx_req(tx_req3), .tx_data(tx_data3), .rx_ack(rx_ack3), .done(done3), .busy(busy3), .err(err3)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = 1'b0;
    #1;
    n_checks++; if (tx_req !== 1'b0) begin n_fail++; $display("FAIL reset_tx_req: got %b want 0", tx_req); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_checks++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: done=%b err=%b want 0/0", done, err); end
    n_checks++; if (s_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_ready: s_ready=%b busy=%b want 1/0", s_ready, busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("reset: released");
  endtask

  task automatic test_basic(input logic [7:0] w);
    logic       prev_req = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] e;
    int         done_cnt = 0;
    bit         ok = 1'b0;
    @(negedge clk);
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL basic_idle_ready: got %b want 1", s_ready); end
    s_data = w;
    s_valid = 1'b1;
    exp_q.push_back(w);
    @(negedge clk);
    s_valid = 1'b0;
    s_data = 8'h00;
    n_checks++; if (tx_req !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_req_rise: tx_req=%b busy=%b want 1/1", tx_req, busy); end
    for (int c = 0; c < 200; c++) begin
      if (c > 0) @(negedge clk);
      if (tx_req && !prev_req) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL basic_sb_empty: tx_data=%h with no word expected", tx_data); end
        else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin n_fail++; $display("FAIL basic_data: got %h want %h", tx_data, e); end
        end
        held = tx_data;
      end else if (tx_req) begin
        n_checks++; if (tx_data !== held) begin n_fail++; $display("FAIL basic_stable: got %h want %h", tx_data, held); end
      end
      if (done) begin
        done_cnt++;
        n_checks++; if (tx_req !== 1'b0) begin n_fail++; $display("FAIL basic_done_req: tx_req=%b want 0 at done", tx_req); end
      end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", err); end
      prev_req = tx_req;
      if (done_cnt > 0 && s_ready) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_complete: handshake not finished in 200 cycles, want done and s_ready"); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    $display("basic: word %h, done pulses %0d", w, done_cnt);
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3] = '{8'h01, 8'h02, 8'h03};
    logic       prev_req = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] e;
    int         idx = 0, pops = 0, done_cnt = 0;
    bit         ok = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (tx_req && !prev_req) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_sb_empty: tx_data=%h with no word expected", tx_data); end
        else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin n_fail++; $display("FAIL b2b_data: got %h want %h", tx_data, e); end
          $display("b2b: word %h observed on tx_data", tx_data);
        end
        pops++;
        held = tx_data;
      end else if (busy) begin
        n_checks++; if (tx_data !== held) begin n_fail++; $display("FAIL b2b_ignored: tx_data=%h want %h while busy", tx_data, held); end
      end
      if (done) done_cnt++;
      prev_req = tx_req;
      if (s_ready) begin
        if (idx < 3) begin
          s_data = words[idx];
          s_valid = 1'b1;
          exp_q.push_back(words[idx]);
          idx++;
        end else begin
          s_valid = 1'b0;
        end
      end else begin
        s_data = 8'hFF;
      end
      if (done_cnt == 3 && s_ready) begin ok = 1'b1; break; end
    end
    s_valid = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_complete: got %0d done pulses in 600 cycles, want 3", done_cnt); end
    n_checks++; if (pops != 3) begin n_fail++; $display("FAIL b2b_requests: got %0d want 3", pops); end
    n_checks++; if (done_cnt != 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 3", done_cnt); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d words pending want 0", exp_q.size()); end
  endtask

  task automatic test_latency();
    bit ok = 1'b0;
    @(negedge clk);
    s_data3 = 8'h3C;
    s_valid3 = 1'b1;
    @(negedge clk);
    s_valid3 = 1'b0;
    n_checks++; if (tx_req3 !== 1'b1 || tx_data3 !== 8'h3C) begin n_fail++; $display("FAIL lat_req: tx_req=%b tx_data=%h want 1/3c", tx_req3, tx_data3); end
    @(negedge clk);
    rx_ack3 = 1'b1;
    @(posedge clk);  // edge K samples the rising ack
    for (int j = 1; j <= 4; j++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (j < 3 && (tx_req3 !== 1'b1 || done3 !== 1'b0)) begin n_fail++; $display("FAIL lat_early_k%0d: tx_req=%b done=%b want 1/0", j, tx_req3, done3); end
      if (j == 3 && (tx_req3 !== 1'b0 || done3 !== 1'b1)) begin n_fail++; $display("FAIL lat_k3: tx_req=%b done=%b want 0/1", tx_req3, done3); end
      if (j == 4 && done3 !== 1'b0) begin n_fail++; $display("FAIL lat_done_width: done=%b want 0", done3); end
    end
    rx_ack3 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (s_ready3) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL lat_release: s_ready=%b want 1 within 20 cycles", s_ready3); end
    $display("latency: LAT=3 word 3c acknowledged");
  endtask

  task automatic test_reset_mid_req();
    ack_mode = 1;
    @(negedge clk);
    s_data = 8'h77;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (tx_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_req_setup: tx_req=%b want 1", tx_req); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (tx_req !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_async: tx_req=%b done=%b err=%b want 0/0/0", tx_req, done, err); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_mode = 0;
    exp_q.delete();
    @(negedge clk);
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", s_ready); end
    $display("reset_mid_req: word 77 dropped");
    test_basic(8'h5A);
  endtask

  task automatic test_timeout();
`ifdef CROSS_CLK_TIMEOUT_EN
    ack_mode = 1;
    @(negedge clk);
    s_data = 8'hC3;
    s_valid = 1'b1;
    @(posedge clk);  // edge N enters REQ
    #1 s_valid = 1'b0;
    for (int j = 1; j <= 17; j++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (j < 16 && (tx_req !== 1'b1 || err !== 1'b0)) begin n_fail++; $display("FAIL to_hold_%0d: tx_req=%b err=%b want 1/0", j, tx_req, err); end
      if (j == 16 && (tx_req !== 1'b0 || err !== 1'b1 || done !== 1'b0)) begin n_fail++; $display("FAIL to_fire: tx_req=%b err=%b done=%b want 0/1/0", tx_req, err, done); end
      if (j == 17 && (err !== 1'b0 || s_ready !== 1'b1)) begin n_fail++; $display("FAIL to_recover: err=%b s_ready=%b want 0/1", err, s_ready); end
    end
    $display("timeout: word c3 abandoned after 16 cycles");
`else
    int bad = 0;
    ack_mode = 1;
    @(negedge clk);
    s_data = 8'hC3;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      n_checks++;
      if (tx_req !== 1'b1 || err !== 1'b0) begin
        n_fail++;
        if (bad < 3) $display("FAIL no_timeout_%0d: tx_req=%b err=%b want 1/0", c, tx_req, err);
        bad++;
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("no_timeout: request held 1000 cycles");
`endif
    ack_mode = 0;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_stuck_ack();
`ifdef CROSS_CLK_TIMEOUT_EN
    ack_mode = 2;
    repeat (5) @(negedge clk);
    s_data = 8'hD4;
    s_valid = 1'b1;
    @(posedge clk);  // edge N enters REQ with ack already high
    #1 s_valid = 1'b0;
    for (int j = 1; j <= 18; j++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (j == 1 && (done !== 1'b1 || tx_req !== 1'b0 || err !== 1'b0)) begin n_fail++; $display("FAIL stuck_done: done=%b tx_req=%b err=%b want 1/0/0", done, tx_req, err); end
      if (j > 1 && j < 17 && (done !== 1'b0 || err !== 1'b0 || s_ready !== 1'b0)) begin n_fail++; $display("FAIL stuck_rel_%0d: done=%b err=%b s_ready=%b want 0/0/0", j, done, err, s_ready); end
      if (j == 17 && (err !== 1'b1 || s_ready !== 1'b1)) begin n_fail++; $display("FAIL stuck_err: err=%b s_ready=%b want 1/1", err, s_ready); end
      if (j == 18 && (err !== 1'b0 || s_ready !== 1'b1)) begin n_fail++; $display("FAIL stuck_idle: err=%b s_ready=%b want 0/1", err, s_ready); end
    end
    ack_mode = 0;
    repeat (15) @(negedge clk);
    $display("stuck_ack: word d4 done, release forced after 16 cycles");
`endif
  endtask

  initial begin
    test_reset();
    test_basic(8'hA5);
    test_back_to_back();
    test_latency();
    test_reset_mid_req();
    test_timeout();
    test_stuck_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
